// File: rtl/udp_send.sv
// udp_send: prepends the 8-byte UDP header to an application payload stream,
// enforces the declared payload length and serves the datagram over AXI-Stream.
module udp_send #(
  parameter int unsigned PAYLOAD_MAX = 1472,
  parameter bit          DEBUG       = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  udpdata_tdata_in,
  input  logic        udpdata_tvalid_in,
  input  logic        udpdata_tlast_in,
  output logic        udpdata_tready_out,
  input  logic [15:0] udpdata_length_in,
  input  logic [15:0] src_port_in,
  input  logic [15:0] dest_port_in,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  input  logic        udp_axis_tready_in,
  output logic        busy_out,
  output logic        len_err_out
);

  localparam int unsigned HdrBytes = 8;
  localparam int unsigned HdrIdxW  = 3;
  localparam int unsigned LenW     = 16;
  localparam int unsigned ByteW    = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    PAD,
    DROP
  } state_e;

  state_e              state_q, state_d;
  logic [HdrIdxW-1:0]  hdr_idx_q, hdr_idx_d;
  logic [LenW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [LenW-1:0]     src_q, src_d;
  logic [LenW-1:0]     dst_q, dst_d;
  logic                len_err_q, len_err_d;

  logic [LenW-1:0]     len_total;
  logic [LenW-1:0]     len_last;
  logic                len_ok;
  logic                last_beat;
  logic                out_fire;
  logic                in_fire;
  logic [ByteW-1:0]    hdr_byte;

  // Length bookkeeping: UDP length field, final payload index, legality of a new length.
  assign len_total = len_q + LenW'(HdrBytes);
  assign len_last  = len_q - LenW'(1);
  assign last_beat = (byte_cnt_q == len_last);
  assign len_ok    = (udpdata_length_in != '0) && (32'(udpdata_length_in) <= PAYLOAD_MAX);

  assign out_fire = udp_axis_tvalid_out && udp_axis_tready_in;
  assign in_fire  = udpdata_tvalid_in && udpdata_tready_out;

  assign busy_out    = (state_q != IDLE);
  assign len_err_out = len_err_q;

  // Header byte selected by hdr_idx, big-endian fields, checksum left as zero.
  always_comb begin
    hdr_byte = '0;
    case (hdr_idx_q)
      3'd0:    hdr_byte = src_q[15:8];
      3'd1:    hdr_byte = src_q[7:0];
      3'd2:    hdr_byte = dst_q[15:8];
      3'd3:    hdr_byte = dst_q[7:0];
      3'd4:    hdr_byte = len_total[15:8];
      3'd5:    hdr_byte = len_total[7:0];
      default: hdr_byte = '0;
    endcase
  end

  // Stream outputs per state; DATA is a zero-latency pass-through of the payload source.
  always_comb begin
    udpdata_tready_out  = 1'b0;
    udp_axis_tdata_out  = '0;
    udp_axis_tvalid_out = 1'b0;
    udp_axis_tlast_out  = 1'b0;
    case (state_q)
      HDR: begin
        udp_axis_tvalid_out = 1'b1;
        udp_axis_tdata_out  = hdr_byte;
      end
      DATA: begin
        udp_axis_tdata_out  = udpdata_tdata_in;
        udp_axis_tvalid_out = udpdata_tvalid_in;
        udpdata_tready_out  = udp_axis_tready_in;
        udp_axis_tlast_out  = last_beat;
      end
      PAD: begin
        udp_axis_tvalid_out = 1'b1;
        udp_axis_tlast_out  = last_beat;
      end
      DROP: begin
        udpdata_tready_out = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, counter and field-latch logic.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (udpdata_tvalid_in) begin
          src_d = src_port_in;
          dst_d = dest_port_in;
          len_d = udpdata_length_in;
          if (len_ok) begin
            state_d   = HDR;
            hdr_idx_d = '0;
          end else begin
            state_d   = DROP;
            len_err_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (out_fire) begin
          hdr_idx_d = hdr_idx_q + HdrIdxW'(1);
          if (hdr_idx_q == HdrIdxW'(HdrBytes - 1)) begin
            state_d    = DATA;
            byte_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (in_fire) begin
          byte_cnt_d = byte_cnt_q + LenW'(1);
          if (last_beat) begin
            if (udpdata_tlast_in) begin
              state_d = IDLE;
            end else begin
              state_d   = DROP;
              len_err_d = 1'b1;
            end
          end else if (udpdata_tlast_in) begin
            state_d   = PAD;
            len_err_d = 1'b1;
          end
        end
      end
      PAD: begin
        if (out_fire) begin
          byte_cnt_d = byte_cnt_q + LenW'(1);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (udpdata_tvalid_in && udpdata_tlast_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hdr_idx_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_err_q  <= len_err_d;
    end
  end

  // Optional probe capturing each accepted output beat for an on-chip logic analyser.
  if (DEBUG) begin : g_ila
    logic [ByteW+1:0] probe_q;
    logic [LenW-1:0]  probe_beats_q;

    // Capture the most recent output beat and a running beat count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        probe_q       <= '0;
        probe_beats_q <= '0;
      end else if (out_fire) begin
        probe_q       <= {udp_axis_tlast_out, busy_out, udp_axis_tdata_out};
        probe_beats_q <= probe_beats_q + LenW'(1);
      end
    end
  end

endmodule

// File: doc/udp_send.md
Name: udp_send

Overview:
- Transmit-side counterpart of the UDP receive path.
- Takes a raw 8-bit application payload stream and prepends the 8-byte UDP header: source port, destination port, length = payload + 8, checksum = 0x0000.
- Serves the result as an 8-bit AXI-Stream to the IP transmit layer.
- Enforces the declared payload length: short frames are zero-padded, long frames are truncated, and both are flagged.

Parameters:
- PAYLOAD_MAX, 1472, largest legal payload in bytes; lengths above this are rejected.
- DEBUG, 0, 1 instantiates the ILA probe on the output stream; no functional effect.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- udpdata_tdata_in  in  8  payload byte from the application
- udpdata_tvalid_in  in  1  payload byte valid
- udpdata_tlast_in  in  1  last payload byte of the frame
- udpdata_tready_out  out  1  payload byte accepted
- udpdata_length_in  in  16  payload byte count; sampled on frame start
- src_port_in  in  16  UDP source port; sampled on frame start
- dest_port_in  in  16  UDP destination port; sampled on frame start
- udp_axis_tdata_out  out  8  byte to the IP layer
- udp_axis_tvalid_out  out  1  output byte valid
- udp_axis_tlast_out  out  1  last byte of the UDP datagram
- udp_axis_tready_in  in  1  IP layer ready
- busy_out  out  1  high in any state other than IDLE
- len_err_out  out  1  one-cycle pulse on a length violation

Behaviour:
- Reset: reset_n low asynchronously forces state IDLE. All counters are cleared and all outputs go to 0. A frame in flight is abandoned mid-stream; recovery is the IP layer's responsibility.
- Transfers: a byte moves only when valid and ready are both high on a rising edge.
- State machine: IDLE, HDR, DATA, PAD, DROP.
- IDLE:
  - tready_out = 0, tvalid_out = 0.
  - When udpdata_tvalid_in = 1, latch src_port_in, dest_port_in and udpdata_length_in (L).
  - If 1 <= L <= PAYLOAD_MAX: go to HDR with hdr_idx = 0.
  - Otherwise: pulse len_err_out and go to DROP.
- HDR:
  - tvalid_out = 1; tready_out = 0.
  - tdata_out = header byte hdr_idx, in this order: src[15:8], src[7:0], dst[15:8], dst[7:0], (L+8)[15:8], (L+8)[7:0], 0x00, 0x00.
  - L+8 is a 16-bit add; no overflow is possible given the PAYLOAD_MAX check.
  - hdr_idx advances on each accepted byte. Acceptance of byte 7 moves to DATA with byte_cnt = 0.
  - tlast_out = 0 throughout.
- DATA (zero-latency pass-through):
  - tdata_out = udpdata_tdata_in.
  - tvalid_out = udpdata_tvalid_in.
  - udpdata_tready_out = udp_axis_tready_in.
  - byte_cnt (16-bit) increments on each accepted byte.
  - tlast_out = (byte_cnt == L-1). It is generated internally and never copied from udpdata_tlast_in.
  - Accepted byte with byte_cnt == L-1 and tlast_in = 1: normal end, go to IDLE.
  - Accepted byte with byte_cnt == L-1 and tlast_in = 0: frame is long. Pulse len_err_out and go to DROP.
  - Accepted byte with byte_cnt < L-1 and tlast_in = 1: frame is short. Pulse len_err_out and go to PAD.
- PAD:
  - tready_out = 0; tvalid_out = 1; tdata_out = 0x00.
  - byte_cnt continues to increment on each accepted pad byte.
  - tlast_out is asserted on byte_cnt == L-1; acceptance of that byte goes to IDLE.
- DROP:
  - tready_out = 1; tvalid_out = 0; input bytes are discarded.
  - An accepted byte with tlast_in = 1 goes to IDLE.
- Latency: the first header byte is presented the cycle after frame start is detected in IDLE. The datagram is always exactly L+8 bytes when it leaves the block.
- Back-pressure: udp_axis_tready_in = 0 holds tdata_out, tvalid_out and tlast_out stable in HDR and PAD. In DATA the payload source is stalled through udpdata_tready_out.
- Simultaneous events: tlast_in on byte L-1 is the normal end and is not an error.
  - Single-byte frame (L=1) with tlast_in on the first payload byte: no error.
  - A new frame's first byte presented in the cycle the block returns to IDLE is taken on the following cycle; the block inserts no idle gap beyond that one cycle.
- len_err_out: at most one pulse per frame.

Test Plan:
- src=0x1F90, dst=0x04D2, L=4, payload 11 22 33 44 with tlast on 0x44, tready_in=1 -> output 1F 90 04 D2 00 0C 00 00 11 22 33 44; tlast only on 0x44; len_err_out=0; busy_out high for 12 cycles.
- Same frame, tready_in toggled 1/0 every cycle -> identical byte sequence; no byte dropped or duplicated; outputs stable while tready_in=0.
- L=6, payload AA BB with tlast on BB -> ... 00 0E 00 00 AA BB 00 00 00 00, tlast on the final 00; one len_err_out pulse.
- L=2, payload 01 02 03 04 with tlast on 04 -> payload out is 01 02 with tlast on 02; 03 and 04 consumed with no output; one len_err_out pulse; next frame processed normally.
- L=0, then L=1473 -> no output bytes; one len_err_out pulse per frame; input drained to tlast each time.
- reset_n driven low during HDR byte 3 -> same-cycle tvalid_out=0, busy_out=0; after release, a fresh L=1 frame emits 9 bytes correctly.
